// File: rtl/mem_responder.sv
// mem_responder: 256x8 RAM with memory-mapped status/input/output registers and a program loader.
// The CPU port is only live in RUN with load_en low; every output is registered.
module mem_responder #(
    parameter logic [7:0] IO_STAT_ADDR = 8'hFD,
    parameter logic [7:0] IO_IN_ADDR   = 8'hFE,
    parameter logic [7:0] IO_OUT_ADDR  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    output logic [7:0] cpu_rdata,
    input  logic [7:0] io_in_data,
    input  logic       io_in_valid,
    output logic       io_in_ready,
    output logic [7:0] io_out_data,
    output logic       io_out_valid,
    input  logic       load_en,
    input  logic [7:0] load_data,
    input  logic       load_valid,
    output logic [7:0] load_addr
);
    typedef enum logic {RUN, LOAD} state_t;
    state_t     state_q, state_d;
    logic [7:0] mem [256];
    logic [7:0] rdata_q, rdata_d, out_data_q, out_data_d, hold_q, hold_d, load_addr_q, load_addr_d;
    logic       out_valid_q, out_valid_d, full_q, full_d;
    logic       cpu_act, is_io, capture, rd_clr, ld_wr, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    always_comb begin
        state_d     = load_en ? LOAD : RUN;
        cpu_act     = (state_q == RUN) && !load_en;
        is_io       = (cpu_addr == IO_STAT_ADDR) || (cpu_addr == IO_IN_ADDR) || (cpu_addr == IO_OUT_ADDR);
        ld_wr       = (state_q == LOAD) && load_valid;
        // capture only happens when empty, so it never collides with a meaningful read-clear
        capture     = io_in_valid && !full_q;
        rd_clr      = cpu_act && !cpu_we && (cpu_addr == IO_IN_ADDR);
        full_d      = capture ? 1'b1 : rd_clr ? 1'b0 : full_q;
        hold_d      = capture ? io_in_data : hold_q;
        out_valid_d = cpu_act && cpu_we && (cpu_addr == IO_OUT_ADDR);
        out_data_d  = out_valid_d ? cpu_wdata : out_data_q;
        load_addr_d = ld_wr ? load_addr_q + 8'd1 : ((state_q == RUN) && load_en) ? 8'h00 : load_addr_q;
        mem_we      = ld_wr || (cpu_act && cpu_we && !is_io);
        mem_addr    = (state_q == LOAD) ? load_addr_q : cpu_addr;
        mem_wdata   = (state_q == LOAD) ? load_data : cpu_wdata;
        rdata_d     = !cpu_act ? 8'h00
                    : cpu_we ? ((is_io && cpu_addr != IO_OUT_ADDR) ? 8'h00 : cpu_wdata)
                    : (cpu_addr == IO_STAT_ADDR) ? {7'b0, full_q}
                    : (cpu_addr == IO_IN_ADDR) ? hold_q
                    : (cpu_addr == IO_OUT_ADDR) ? out_data_q
                    : mem[cpu_addr];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            rdata_q     <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
            hold_q      <= 8'h00;
            load_addr_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            full_q      <= full_d;
            hold_q      <= hold_d;
            load_addr_q <= load_addr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && mem_we)
            mem[mem_addr] <= mem_wdata;
    end
    assign cpu_rdata    = rdata_q;
    assign io_in_ready  = !full_q;
    assign io_out_data  = out_data_q;
    assign io_out_valid = out_valid_q;
    assign load_addr    = load_addr_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst, cpu_we, io_in_valid, io_in_ready, io_out_valid, load_en, load_valid;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, io_in_data, io_out_data, load_data, load_addr;
    mem_responder dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .io_in_data(io_in_data), .io_in_valid(io_in_valid),
        .io_in_ready(io_in_ready), .io_out_data(io_out_data), .io_out_valid(io_out_valid),
        .load_en(load_en), .load_data(load_data), .load_valid(load_valid), .load_addr(load_addr)
    );
    int total = 0, bad = 0;
    logic [7:0] m_mem [256];
    bit         m_ok [256];
    logic [7:0] m_rd, m_od, m_hold, m_la;
    bit         m_ov, m_full, m_load, m_rd_ok, m_hold_ok;
    logic [7:0] last;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask
    // Applies one clock edge worth of behaviour using the inputs seen at that edge.
    task automatic model_step();
        bit act;
        logic [7:0] a;
        a = cpu_addr;
        if (rst) begin
            m_rd = 8'h00; m_rd_ok = 1; m_od = 8'h00; m_ov = 0; m_full = 0;
            m_la = 8'h00; m_load = 0; m_hold_ok = 0;
            return;
        end
        act = !m_load && !load_en;
        m_rd_ok = 1;
        if (!act) m_rd = 8'h00;
        else if (cpu_we) begin
            if (a == 8'hFF) m_rd_ok = 0;
            else if (a >= 8'hFD) m_rd = 8'h00;
            else m_rd = cpu_wdata;
        end
        else if (a == 8'hFD) m_rd = {7'b0, m_full};
        else if (a == 8'hFE) begin m_rd = m_hold; m_rd_ok = m_hold_ok; end
        else if (a == 8'hFF) m_rd = m_od;
        else begin m_rd = m_mem[a]; m_rd_ok = m_ok[a]; end
        m_ov = act && cpu_we && a == 8'hFF;
        if (m_ov) m_od = cpu_wdata;
        if (act && cpu_we && a < 8'hFD) begin m_mem[a] = cpu_wdata; m_ok[a] = 1; end
        if (io_in_valid && !m_full) begin m_hold = io_in_data; m_hold_ok = 1; m_full = 1; end
        else if (act && !cpu_we && a == 8'hFE) m_full = 0;
        if (m_load && load_valid) begin m_mem[m_la] = load_data; m_ok[m_la] = 1; m_la = m_la + 8'd1; end
        else if (!m_load && load_en) m_la = 8'h00;
        m_load = load_en;
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (m_rd_ok) check("rdata", cpu_rdata, m_rd);
        check("out_valid", {7'b0, io_out_valid}, {7'b0, m_ov});
        check("out_data", io_out_data, m_od);
        check("in_ready", {7'b0, io_in_ready}, {7'b0, !m_full});
        check("load_addr", load_addr, m_la);
    endtask
    initial begin
        rst = 1; cpu_we = 0; cpu_addr = 8'h00; cpu_wdata = 8'h00; io_in_valid = 0; io_in_data = 8'h00;
        load_en = 0; load_data = 8'h00; load_valid = 0;
        m_rd = 0; m_od = 0; m_hold = 0; m_la = 0; m_ov = 0; m_full = 0; m_load = 0; m_rd_ok = 0; m_hold_ok = 0;
        for (int i = 0; i < 256; i++) begin m_ok[i] = 0; m_mem[i] = 8'h00; end
        tick(); tick();
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_ready", {7'b0, io_in_ready}, 8'h01);
        check("rst_la", load_addr, 8'h00);
        check("rst_ov", {7'b0, io_out_valid}, 8'h00);
        check("rst_od", io_out_data, 8'h00);
        rst = 0;
        load_en = 1; tick();
        load_valid = 1;
        for (int i = 0; i < 257; i++) begin load_data = 8'($urandom); last = load_data; tick(); end
        check("wrap_la", load_addr, 8'h01);
        load_valid = 0; load_en = 0; tick();
        cpu_addr = 8'h00; tick();
        check("wrap_mem0", cpu_rdata, last);
        load_en = 1; tick();
        load_valid = 1;
        for (int i = 0; i < 4; i++) begin load_data = 8'(8'hA0 + i); tick(); end
        load_valid = 0; load_en = 0; tick();
        for (int i = 0; i < 4; i++) begin cpu_addr = 8'(i); tick(); check("load_rd", cpu_rdata, 8'(8'hA0 + i)); end
        cpu_we = 1; cpu_addr = 8'hFF; cpu_wdata = 8'h5A; tick();
        check("out_v1", {7'b0, io_out_valid}, 8'h01); check("out_d1", io_out_data, 8'h5A);
        cpu_wdata = 8'h3C; tick();
        check("out_v2", {7'b0, io_out_valid}, 8'h01); check("out_d2", io_out_data, 8'h3C);
        cpu_we = 0; cpu_addr = 8'h00; tick();
        check("out_v3", {7'b0, io_out_valid}, 8'h00);
        cpu_addr = 8'hFF; tick();
        check("out_rd", cpu_rdata, 8'h3C);
        io_in_valid = 1; io_in_data = 8'h77; tick(); io_in_valid = 0;
        check("in_busy", {7'b0, io_in_ready}, 8'h00);
        cpu_addr = 8'hFD; tick(); check("stat1", cpu_rdata, 8'h01);
        cpu_addr = 8'hFE; tick(); check("in_data", cpu_rdata, 8'h77);
        cpu_addr = 8'hFD; tick(); check("stat0", cpu_rdata, 8'h00);
        check("in_free", {7'b0, io_in_ready}, 8'h01);
        cpu_we = 1; cpu_addr = 8'hFE; cpu_wdata = 8'h33; tick(); check("wr_in_ign", cpu_rdata, 8'h00);
        cpu_addr = 8'h10; cpu_wdata = 8'hEE; tick(); check("wr_first", cpu_rdata, 8'hEE);
        load_en = 1; cpu_wdata = 8'h11; tick(); check("load_rd0", cpu_rdata, 8'h00);
        tick();
        load_en = 0; cpu_we = 0; tick(); tick();
        check("isolate", cpu_rdata, 8'hEE);
        io_in_valid = 1; io_in_data = 8'h21; cpu_addr = 8'h00; tick(); io_in_valid = 0;
        load_en = 1; tick();
        load_valid = 1; load_data = 8'h42; tick();
        rst = 1; load_data = 8'h99; io_in_valid = 1; io_in_data = 8'h05; tick();
        check("mid_rst_la", load_addr, 8'h00);
        check("mid_rst_ready", {7'b0, io_in_ready}, 8'h01);
        check("mid_rst_rd", cpu_rdata, 8'h00);
        rst = 0; load_valid = 0; io_in_valid = 0; tick();
        check("restart_la", load_addr, 8'h00);
        check("restart_ready", {7'b0, io_in_ready}, 8'h01);
        load_valid = 1; load_data = 8'h55; tick();
        check("restart_la1", load_addr, 8'h01);
        load_valid = 0; load_en = 0; tick();
        cpu_addr = 8'h01; tick(); check("rst_cell", cpu_rdata, 8'hA1);
        cpu_addr = 8'h00; tick(); check("restart_cell", cpu_rdata, 8'h55);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) load_en = !load_en;
            load_valid = 1'($urandom); load_data = 8'($urandom);
            cpu_we = 1'($urandom); cpu_wdata = 8'($urandom);
            cpu_addr = $urandom_range(0, 1) ? 8'($urandom_range(248, 255)) : 8'($urandom);
            io_in_valid = !load_en && !m_load && ($urandom_range(0, 3) == 0);
            io_in_data = 8'($urandom);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter IO_STAT_ADDR, 8'hFD, read-only status register address.
REQ-002 Parameter IO_IN_ADDR, 8'hFE, input-port data address (read-to-clear).
REQ-003 Parameter IO_OUT_ADDR, 8'hFF, output-port data address.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port cpu_addr  input  8  CPU access address.
REQ-007 Port cpu_wdata  input  8  CPU write data.
REQ-008 Port cpu_we  input  1  CPU write enable; 0 = read cycle.
REQ-009 Port cpu_rdata  output  8  registered read data returned to CPU.
REQ-010 Port io_in_data  input  8  external input byte.
REQ-011 Port io_in_valid  input  1  external input byte offered.
REQ-012 Port io_in_ready  output  1  holding register empty; byte accepted when valid&&ready.
REQ-013 Port io_out_data  output  8  last byte written to IO_OUT_ADDR.
REQ-014 Port io_out_valid  output  1  one-cycle strobe on each write to IO_OUT_ADDR.
REQ-015 Port load_en  input  1  program-load mode request; CPU side ignored while high.
REQ-016 Port load_data  input  8  program byte.
REQ-017 Port load_valid  input  1  program byte strobe.
REQ-018 Port load_addr  output  8  current load write pointer.

Function
REQ-019 Storage SHALL be 256x8 RAM; RAM contents SHALL NOT be cleared by reset.
REQ-020 Mode FSM SHALL have states RUN and LOAD; RUN->LOAD when load_en=1, LOAD->RUN when load_en=0, evaluated each cycle.
REQ-021 On every RUN->LOAD transition, load_addr SHALL be set to 8'h00.
REQ-022 In LOAD, each cycle with load_valid=1 SHALL write mem[load_addr]<=load_data and increment load_addr, wrapping 8'hFF->8'h00.
REQ-023 In LOAD, cpu_we SHALL be ignored, cpu_rdata SHALL be driven 8'h00, and no I/O side effects SHALL occur.
REQ-024 In LOAD the loader SHALL be able to write all 256 RAM cells, including those shadowed by I/O addresses.
REQ-025 In RUN, read (cpu_we=0) of a RAM address (8'h00-8'hFC at defaults) SHALL present mem[cpu_addr] on cpu_rdata exactly one cycle later.
REQ-026 In RUN, write to a RAM address SHALL update mem on that edge, and cpu_rdata SHALL show cpu_wdata the next cycle (write-first).
REQ-027 Write to IO_OUT_ADDR SHALL set io_out_data<=cpu_wdata and io_out_valid=1 for exactly the next cycle, with no RAM update; back-to-back writes SHALL yield back-to-back strobes.
REQ-028 Read of IO_OUT_ADDR SHALL return io_out_data one cycle later.
REQ-029 io_in_ready SHALL equal !in_full; io_in_valid&&io_in_ready SHALL capture io_in_data into the holding register and set in_full.
REQ-030 Read of IO_IN_ADDR SHALL return the holding register one cycle later and clear in_full on the same edge; reading while empty SHALL return the stale value and leave in_full at 0.
REQ-031 A capture and a read-clear SHALL never coincide, since capture requires in_full=0.
REQ-032 Writes to IO_IN_ADDR and IO_STAT_ADDR SHALL be ignored; cpu_rdata SHALL be 8'h00 the next cycle.
REQ-033 Read of IO_STAT_ADDR SHALL return {7'b0, in_full} one cycle later.
REQ-034 No combinational path SHALL exist from cpu_* inputs to any output.

Reset
REQ-035 While rst=1: cpu_rdata=8'h00, io_out_data=8'h00, io_out_valid=0, in_full=0 (io_in_ready=1), load_addr=8'h00, FSM=RUN.
REQ-036 While rst=1, a RAM write requested in that cycle (CPU or loader) SHALL be suppressed and no input byte SHALL be captured.
REQ-037 After rst deasserts with load_en=1, the FSM SHALL enter LOAD and start loading at address 8'h00.

Verification
REQ-038 Load: load_en=1, bytes 8'hA0..8'hA3 with load_valid; load_en=0; CPU reads 0x00..0x03 -> cpu_rdata A0,A1,A2,A3, each one cycle after its address.
REQ-039 Wrap: 257 load strobes starting from 8'h00 -> load_addr returns to 8'h01; mem[0x00] holds byte 257.
REQ-040 Output: CPU writes 8'h5A then 8'h3C to 0xFF on consecutive cycles -> io_out_valid high two cycles; io_out_data 5A then 3C.
REQ-041 Input: io_in_data=8'h77 valid -> io_in_ready drops; read 0xFD -> 8'h01; read 0xFE -> 8'h77; read 0xFD again -> 8'h00; io_in_ready back to 1.
REQ-042 Reset mid-operation: rst=1 during a load strobe and with in_full=1 -> the strobed cell is unchanged, load_addr=0, io_in_ready=1, cpu_rdata=0.
REQ-043 Write-first and isolation: CPU writes 8'hEE to 0x10 -> cpu_rdata EE next cycle; with load_en=1, a CPU write of 8'h11 to 0x10 -> mem[0x10] remains EE.
